// File: rtl/contador_mod_n_cascada_pkg.sv
// Shared definitions for the cascaded modulo-N counter: direction and mode
// encodings plus a clog2 helper used to size each digit from its modulus.
package contador_defs;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;
  localparam logic MODE_SAT  = 1'b0;

  // Smallest r with 2**r >= value; bounded loop keeps it elaboration friendly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_mod_n_cascada_digito_ud.sv
// One modulo-N up/down digit with clamped parallel load and terminal flags.
module contador_digito_ud
  import contador_defs::*;
#(
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          step_i,
  input  logic          up_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  input  logic [DW:0]   modulus_i,
  output logic [DW-1:0] value_o,
  output logic          term_up_o,
  output logic          term_dn_o
);

  localparam logic [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] ZERO = {DW{1'b0}};

  logic [DW-1:0] value_q;
  logic [DW-1:0] value_d;
  logic [DW:0]   n_minus1_s;

  assign n_minus1_s = modulus_i - {{DW{1'b0}}, 1'b1};
  // Out-of-range values (>= N) also count as terminal so an up step recovers to 0.
  assign term_up_o  = ({1'b0, value_q} >= n_minus1_s);
  assign term_dn_o  = (value_q == ZERO);
  assign value_o    = value_q;

  // Next digit value: load (clamped to N-1) wins over a step.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      if ({1'b0, load_val_i} >= modulus_i) begin
        value_d = n_minus1_s[DW-1:0];
      end else begin
        value_d = load_val_i;
      end
    end else if (step_i) begin
      case (up_i)
        CNT_UP:   value_d = term_up_o ? ZERO : (value_q + ONE);
        CNT_DOWN: value_d = term_dn_o ? n_minus1_s[DW-1:0] : (value_q - ONE);
        default:  value_d = value_q;
      endcase
    end else begin
      value_d = value_q;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= ZERO;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/contador_mod_n_cascada.sv
// Multi-digit modulo-N up/down counter: ripple terminal chain, wrap or
// saturate at the full roll-over, and a zero-latency carry for chaining.
module contador_mod_n_cascada
  import contador_defs::*;
#(
  parameter int N      = 10,
  parameter int DW     = clog2(N),
  parameter int DIGITS = 4
) (
  input  logic                 clk_50MHz_i,
  input  logic                 rst_sync_ha_i,
  input  logic                 enable_i,
  input  logic                 up_i,
  input  logic                 wrap_i,
  input  logic                 load_i,
  input  logic [DIGITS*DW-1:0] carga_i,
  output logic [DIGITS*DW-1:0] conteo_salida_o,
  output logic                 enable_out,
  output logic                 sat_o
);

  localparam logic [DW:0] MODULUS = (DW+1)'(N);

  logic [DIGITS-1:0] term_up_s;
  logic [DIGITS-1:0] term_dn_s;
  logic [DIGITS-1:0] term_s;
  logic [DIGITS-1:0] below_s;
  logic [DIGITS-1:0] step_s;
  logic              all_term_s;
  logic              carry_s;
  logic              suppress_s;
  logic              sat_q;
  logic              sat_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    contador_digito_ud #(.DW(DW)) u_digit (
      .clk_i      (clk_50MHz_i),
      .rst_i      (rst_sync_ha_i),
      .step_i     (step_s[g]),
      .up_i       (up_i),
      .load_i     (load_i),
      .load_val_i (carga_i[g*DW +: DW]),
      .modulus_i  (MODULUS),
      .value_o    (conteo_salida_o[g*DW +: DW]),
      .term_up_o  (term_up_s[g]),
      .term_dn_o  (term_dn_s[g])
    );
  end

  // Ripple AND: below_s[k] means every digit under k sits at its terminal value.
  always_comb begin
    logic run;
    run    = 1'b1;
    term_s = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      term_s[k]  = (up_i == CNT_UP) ? term_up_s[k] : term_dn_s[k];
      below_s[k] = run;
      run        = run & term_s[k];
    end
    all_term_s = run;
  end

  assign carry_s    = enable_i & all_term_s;
  assign suppress_s = carry_s & (wrap_i != MODE_WRAP);
  assign enable_out = carry_s;

  // Per-digit step enables; a saturated roll-over freezes every digit.
  always_comb begin
    step_s = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      step_s[k] = enable_i & ~suppress_s & below_s[k];
    end
  end

  // Saturation flag: any unsuppressed enabled cycle changes digit 0, so it clears.
  always_comb begin
    sat_d = sat_q;
    if (load_i) begin
      sat_d = 1'b0;
    end else if (suppress_s) begin
      sat_d = 1'b1;
    end else if (enable_i) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  // Saturation flag register.
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;

endmodule
